// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DEF = 8;
   localparam int W_DEF = 2;

   function automatic int digits(input int n, input int w);
      return n / w;
   endfunction

   function automatic int cnt_bits(input int n, input int w);
      return (n / w > 1) ? $clog2(n / w) : 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
interface serial_subtractor_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         b_in;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] d;
   logic         b_out;
   logic         ovf;
   logic         zero;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, d, b_out, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, d, b_out, ovf, zero
   );
endinterface

// File: rtl/serial_subtractor_sub_slice.sv
// W-bit ripple slice computing x + ~y + c_in, exposing the carry into its MSB.
module sub_slice #(
   parameter int W = 2
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         c_in,
   output logic [W-1:0] s,
   output logic         c_msb,
   output logic         c_out
);
   logic [W:0]   c;
   logic [W-1:0] g;
   logic [W-1:0] p;

   always_comb begin
      c    = '0;
      g    = '0;
      p    = '0;
      s    = '0;
      c[0] = c_in;
      for (int i = 0; i < W; i++) begin
         g[i]   = x[i] & ~y[i];
         p[i]   = x[i] ^ ~y[i];
         s[i]   = p[i] ^ c[i];
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign c_msb = c[W-1];
   assign c_out = c[W];
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: d = a - b - b_in, W bits per cycle.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int ND = digits(N, W);
   localparam int CW = cnt_bits(N, W);

   state_t state;
   state_t nxt;

   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [N-1:0]  r_sh;
   logic [N-1:0]  r_nx;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          last;

   logic [N-1:0]  d_q;
   logic          b_out_q;
   logic          ovf_q;
   logic          zero_q;

   logic [W-1:0]  s;
   logic          c_msb;
   logic          c_out;

   sub_slice #(.W(W)) u_slice (
      .x    (a_sh[W-1:0]),
      .y    (b_sh[W-1:0]),
      .c_in (carry),
      .s    (s),
      .c_msb(c_msb),
      .c_out(c_out)
   );

   // New digit enters at the top so the LSB digit ends up at bit 0.
   assign r_nx = (r_sh >> W) | (N'(s) << (N - W));
   assign last = (cnt == CW'(ND - 1));

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (bus.in_valid) nxt = BUSY;
         BUSY:    if (last) nxt = DONE;
         DONE:    if (bus.out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         d_q     <= '0;
         b_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= ~bus.b_in;
            cnt   <= '0;
         end else if (state == BUSY) begin
            a_sh  <= a_sh >> W;
            b_sh  <= b_sh >> W;
            r_sh  <= r_nx;
            carry <= c_out;
            cnt   <= cnt + CW'(1);
            if (last) begin
               d_q     <= r_nx;
               b_out_q <= ~c_out;
               ovf_q   <= c_msb ^ c_out;
               zero_q  <= (r_nx == '0);
            end
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.d         = d_q;
   assign bus.b_out     = b_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (N=8, W=2).
module tb_serial_subtractor;
   localparam int N  = 8;
   localparam int W  = 2;
   localparam int ND = N / W;

   typedef struct {
      logic [N-1:0] d;
      logic         bo;
      logic         ov;
      logic         z;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_acc = -1;
   exp_t sb[$];

   serial_subtractor_if #(.N(N)) bus ();

   serial_subtractor #(.N(N), .W(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a,
                                  input logic [N-1:0] b,
                                  input logic bin);
      exp_t e;
      int u, sa, sb_, r;
      u  = int'(a) - int'(b) - int'(bin);
      sa = int'($signed(a));
      sb_ = int'($signed(b));
      r  = sa - sb_ - int'(bin);
      e.d  = N'(u);
      e.bo = (u < 0);
      e.ov = (r < -(1 << (N - 1))) || (r > (1 << (N - 1)) - 1);
      e.z  = (e.d == '0);
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 32'(bus.d), 32'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("d", 32'(bus.d), 32'(e.d));
            check("b_out", 32'(bus.b_out), 32'(e.bo));
            check("ovf", 32'(bus.ovf), 32'(e.ov));
            check("zero", 32'(bus.zero), 32'(e.z));
         end
      end
   end

   task automatic wait_ready();
      int k;
      k = 0;
      while (!bus.in_ready && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bin, input int hold,
                        input bit chk_space);
      exp_t e;
      int   acc;
      wait_ready();
      e = model(a, b, bin);
      bus.a         = a;
      bus.b         = b;
      bus.b_in      = bin;
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      acc = cyc;
      #1;
      bus.in_valid = 1'b0;
      bus.a        = N'($urandom);
      bus.b        = N'($urandom);
      bus.b_in     = 1'($urandom);
      sb.push_back(e);
      if (chk_space && last_acc >= 0)
         check("spacing", 32'(acc - last_acc), 32'(ND + 2));
      last_acc = acc;
      for (int k = 1; k <= ND; k++) begin
         @(posedge clk);
         #1;
         check("lat_valid", 32'(bus.out_valid), 32'(k == ND));
      end
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'($urandom);
         bus.a        = N'($urandom);
         @(posedge clk);
         #1;
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_ready", 32'(bus.in_ready), 32'd0);
         check("hold_d", 32'(bus.d), 32'(e.d));
         check("hold_flags", {29'd0, bus.b_out, bus.ovf, bus.zero},
               {29'd0, e.bo, e.ov, e.z});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("idle_valid", 32'(bus.out_valid), 32'd0);
      check("idle_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] ra, rb;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.b_in      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_d", 32'(bus.d), 32'd0);
      check("rst_flags", {29'd0, bus.b_out, bus.ovf, bus.zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
      do_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h00, 8'hFF, 1'b1, 0, 1'b0);
      do_op(8'h10, 8'h01, 1'b0, 3, 1'b0);

      // Abandon an operation mid-flight with reset.
      wait_ready();
      bus.a        = 8'h20;
      bus.b        = 8'h01;
      bus.b_in     = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_d", 32'(bus.d), 32'd0);
      check("mid_rst_flags", {29'd0, bus.b_out, bus.ovf, bus.zero}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      repeat (ND + 2) @(posedge clk);
      #1;
      check("post_rst_quiet", 32'(bus.out_valid), 32'd0);
      do_op(8'h09, 8'h09, 1'b0, 0, 1'b0);

      last_acc = -1;
      for (int i = 0; i < 20; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         if (i == 0) ra = 8'h7F;
         if (i == 0) rb = 8'h80;
         if (i == 1) ra = 8'hFF;
         if (i == 1) rb = 8'hFF;
         do_op(ra, rb, 1'($urandom), 0, 1'b1);
      end

      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, digit-serial two's-complement subtractor computing d = a - b - b_in over N bits.
- Processes W bits per cycle, LSB digit first, using a W-bit ripple-borrow slice. This trades latency for area against the single-cycle ripple-carry adder.
- Valid/ready handshake on both input and output.
- Sits beside the adder in the arithmetic datapath: decrement, compare and difference paths.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of W.
- W, 2, digit width processed per cycle; 1 <= W <= N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  N  minuend
- b  input  N  subtrahend
- b_in  input  1  borrow in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- d  output  N  difference, a - b - b_in mod 2^N
- b_out  output  1  unsigned borrow out; 1 iff a < b + b_in (unsigned)
- ovf  output  1  signed overflow; true result not representable in N-bit two's complement
- zero  output  1  d == 0

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0.
  - d, b_out, ovf, zero = 0; internal shift registers and borrow flop = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. If in_valid at the edge, capture a, b and carry flop = ~b_in, clear digit counter, go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each cycle process digit k = a[kW+:W] + ~b[kW+:W] + carry. Store the W-bit sum into the result shift register and update carry.
    - Counter increments 0..N/W-1. On the edge completing digit N/W-1, load the result registers and go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_valid && out_ready go to IDLE. Otherwise hold d, b_out, ovf, zero stable.
- Latency: out_valid is high exactly N/W cycles after the accepting edge. Defaults give 4 cycles. Throughput is at most one operation per N/W+2 cycles.
- No input/output overlap: the block does not accept new operands in DONE, even if out_ready is high the same cycle.
- Result rules:
  - b_out = ~(final carry).
  - ovf = carry into bit N-1 XOR carry out of bit N-1, with carries in the inverted-b formulation. The slice must therefore expose its internal carry into its MSB.
  - zero is computed from the full registered d.
- d, b_out, ovf and zero update only on the BUSY→DONE transition. They retain the last result in IDLE and BUSY, and are meaningful only while out_valid=1.
- Operands change while BUSY: ignored; the block uses its captured copies.
- in_valid deasserted in IDLE: no action.
- Reset mid-operation: the operation is abandoned and no out_valid pulse is produced. The block returns to IDLE with all outputs at reset values.
- W == N: a single BUSY cycle, latency 1.

Decomposition:
- Package serial_sub_pkg:
  - state enum type (IDLE, BUSY, DONE), 2-bit encoding.
  - localparam helper for digit count N/W and counter width $clog2(N/W) (minimum 1).
- Sub-module sub_slice, purely combinational, parameter W:
  - inputs x[W], y[W], c_in; outputs s[W], c_msb (carry into bit W-1), c_out.
  - implements x + ~y + c_in with ripple generate/propagate.
- Top-level holds the FSM, counter, shift registers and result registers.

Test Plan (N=8, W=2):
- a=8'h05, b=8'h03, b_in=0 → after 4 cycles out_valid=1; d=8'h02, b_out=0, ovf=0, zero=0.
- a=8'h03, b=8'h05, b_in=0 → d=8'hFE, b_out=1, ovf=0, zero=0.
- a=8'h80, b=8'h01, b_in=0 → d=8'h7F, b_out=0, ovf=1. Then a=8'h00, b=8'hFF, b_in=1 → d=8'h00, b_out=1, ovf=0, zero=1.
- Backpressure: a=8'h10, b=8'h01, hold out_ready=0 for 3 cycles → out_valid, d=8'h0F, b_out, ovf, zero all stable; in_ready=0 throughout. in_valid pulses during this window are ignored. Raising out_ready returns the block to IDLE next edge.
- Reset mid-op: assert rst after 2 BUSY cycles of a=8'h20, b=8'h01 → out_valid=0 and outputs 0 immediately (async); in_ready=1 after release. Next op a=8'h09, b=8'h09 gives d=8'h00, zero=1, b_out=0.
- Back-to-back: 20 random ops with out_ready=1 → each result matches a - b - b_in reference; acceptance spacing is N/W+2 cycles.
